// File: rtl/text_attr_renderer.sv
// VGA text-mode pixel renderer with a fixed 4-cycle pipeline.
// It fetches a char/attr word, then a glyph row, then resolves the pixel colour.
module text_attr_renderer #(
  parameter int COLS       = 80,
  parameter int ROWS       = 30,
  parameter int FONT_H     = 16,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ADDR_W     = 12,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                             clk25mhz,
  input  logic                             rst_n,
  input  logic [9:0]                       hindex,
  input  logic [9:0]                       vindex,
  input  logic                             attr_mode,
  input  logic [3:0]                       standard,
  input  logic [3:0]                       emphasized,
  input  logic [3:0]                       background,
  input  logic                             cursor_en,
  input  logic [6:0]                       cursor_col,
  input  logic [4:0]                       cursor_row,
  input  logic [15:0]                      char_data,
  input  logic [7:0]                       font_data,
  output logic [ADDR_W-1:0]                char_address,
  output logic [8+$clog2(FONT_H)-1:0]      font_address,
  output logic [7:0]                       color,
  output logic [BLINK_LOG2-1:0]            frame_cnt
);
  localparam int FW = $clog2(FONT_H);
  localparam int RW = 10 - FW;

  if (COLS * 8 != H_ACTIVE || ROWS * FONT_H != V_ACTIVE) begin : g_bad_geom
    $error("text_attr_renderer: geometry parameters are inconsistent");
  end

  // Raster decode
  logic          active;
  logic [6:0]    col;
  logic [2:0]    xs;
  logic [RW-1:0] row;
  logic [FW-1:0] yl;
  logic          curhit;

  assign active = (hindex < 10'(H_ACTIVE)) && (vindex < 10'(V_ACTIVE));
  assign col    = hindex[9:3];
  assign xs     = hindex[2:0];
  assign row    = vindex[9:FW];
  assign yl     = vindex[FW-1:0];
  assign curhit = cursor_en && (col == cursor_col) && (row == RW'(cursor_row)) &&
                  (yl >= FW'(FONT_H - 2));

  // S1
  logic [ADDR_W-1:0] char_addr_q, char_addr_d;
  logic [2:0]        xs1_q;
  logic [FW-1:0]     yl1_q;
  logic              vld1_q, cur1_q;

  assign char_addr_d = active ? (ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col)) : char_addr_q;

  // S2
  logic [8+FW-1:0] font_addr_q, font_addr_d;
  logic [7:0]      attr2_q;
  logic            c7_2_q;
  logic [2:0]      xs2_q;
  logic            vld2_q, cur2_q;

  assign font_addr_d = attr_mode ? {char_data[7:0], yl1_q}
                                 : {1'b0, char_data[6:0], yl1_q};

  // S3
  logic [3:0]            idx_q, idx_d;
  logic [3:0]            fg, bg;
  logic                  on, blink, phase;
  logic [BLINK_LOG2-1:0] frame_q, frame_d;

  assign phase = frame_q[BLINK_LOG2-1];

  // Blink suppresses the glyph before the cursor inverts it, so the cursor survives blink.
  always_comb begin
    on = font_data[~xs2_q];
    if (attr_mode) begin
      fg    = attr2_q[3:0];
      bg    = {1'b0, attr2_q[6:4]};
      blink = attr2_q[7];
    end else begin
      fg    = c7_2_q ? emphasized : standard;
      bg    = background;
      blink = 1'b0;
    end
    if (blink && phase)    on = 1'b0;
    if (cur2_q && !phase)  on = !on;
    idx_d = !vld2_q ? 4'h0 : (on ? fg : bg);
  end

  // S4
  logic [7:0] color_q, color_d;
  logic [2:0] rgb, bright;

  assign rgb     = idx_q[2:0];
  assign bright  = idx_q[3] ? ((rgb == 3'b000) ? 3'b111 : rgb) : 3'b000;
  assign color_d = {rgb[2], bright[2], 1'b0, rgb[1], bright[1], 1'b0, rgb[0], bright[0]};

  assign frame_d = (hindex == 10'd0 && vindex == 10'(V_ACTIVE)) ? frame_q + 1'b1 : frame_q;

  always_ff @(posedge clk25mhz or negedge rst_n) begin
    if (!rst_n) begin
      char_addr_q <= '0;
      xs1_q       <= '0;
      yl1_q       <= '0;
      vld1_q      <= 1'b0;
      cur1_q      <= 1'b0;
      font_addr_q <= '0;
      attr2_q     <= '0;
      c7_2_q      <= 1'b0;
      xs2_q       <= '0;
      vld2_q      <= 1'b0;
      cur2_q      <= 1'b0;
      idx_q       <= '0;
      color_q     <= '0;
      frame_q     <= '0;
    end else begin
      char_addr_q <= char_addr_d;
      xs1_q       <= xs;
      yl1_q       <= yl;
      vld1_q      <= active;
      cur1_q      <= curhit;
      font_addr_q <= font_addr_d;
      attr2_q     <= char_data[15:8];
      c7_2_q      <= char_data[7];
      xs2_q       <= xs1_q;
      vld2_q      <= vld1_q;
      cur2_q      <= cur1_q;
      idx_q       <= idx_d;
      color_q     <= color_d;
      frame_q     <= frame_d;
    end
  end

  assign char_address = char_addr_q;
  assign font_address = font_addr_q;
  assign color        = color_q;
  assign frame_cnt    = frame_q;
endmodule
